// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the instruction fetch stage.
// Imported by the fetch queue and the fetch unit top level.
package fetch_pkg;

  localparam int unsigned      PC_W      = 8;
  localparam int unsigned      ROM_WORDS = 12;
  localparam logic [PC_W-1:0]  RESET_PC  = 8'h00;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue2.sv
// Two-entry FIFO between ROM return and decode.
// Entry 0 is always the head; when the queue empties the head keeps its last contents.
module fetch_queue2
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t e0, e1;
  logic [1:0]   cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (cnt)
        2'd0: begin
          if (push) begin
            e0  <= push_data;
            cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            e0 <= push_data;
          end else if (push) begin
            e1  <= push_data;
            cnt <= 2'd2;
          end else if (pop) begin
            cnt <= 2'd0;
          end
        end
        default: begin
          // Full: shift entry 1 forward on pop; a push can only arrive together with a pop.
          if (pop) begin
            e0 <= e1;
            if (push) begin
              e1 <= push_data;
            end else begin
              cnt <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  assign head  = e0;
  assign count = cnt;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues word reads to a 1-cycle-latency ROM,
// buffers returned words and hands {pc, instr} to decode over valid/ready.
module instruction_fetch_unit #(
  parameter int unsigned      PC_W      = fetch_pkg::PC_W,
  parameter int unsigned      ROM_WORDS = fetch_pkg::ROM_WORDS,
  parameter logic [PC_W-1:0]  RESET_PC  = fetch_pkg::RESET_PC,
  parameter int unsigned      QDEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [5:0]      rom_addr,
  input  logic [31:0]     rom_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [PC_W-1:0] id_pc,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic            fetch_done
);

  import fetch_pkg::*;

  localparam logic [PC_W-3:0] ROM_LIMIT = (PC_W-2)'(ROM_WORDS);

  fetch_state_t    state, state_d;
  logic [PC_W-1:0] pc, inflight_pc, tgt_pc;
  logic [PC_W-3:0] pc_word, tgt_word;
  logic            inflight;
  logic [5:0]      rom_addr_q;
  logic [1:0]      count;
  logic [2:0]      occupancy, issue_limit;
  logic            accept, pop, push, issue;
  fetch_entry_t    push_entry, head;

  assign pc_word  = pc[PC_W-1:2];
  assign tgt_pc   = br_target & ~PC_W'(3);
  assign tgt_word = tgt_pc[PC_W-1:2];

  assign accept = id_valid & id_ready;
  assign pop    = accept & ~br_taken;
  assign push   = inflight & ~br_taken;

  // A head leaving this cycle frees a slot, so counting it keeps the stream back-to-back.
  assign occupancy   = {1'b0, count} + {2'b00, inflight};
  assign issue_limit = 3'(QDEPTH) + {2'b00, accept};

  assign issue = (state == RUN) && !br_taken && (pc_word < ROM_LIMIT)
                 && (occupancy < issue_limit);

  assign rom_addr   = issue ? 6'(pc_word) : rom_addr_q;
  assign fetch_done = (state == HALT);

  always_comb begin
    state_d = state;
    if (br_taken) begin
      if (tgt_word < ROM_LIMIT) begin
        state_d = RUN;
      end
    end else if ((state == RUN) && (pc_word >= ROM_LIMIT)) begin
      state_d = HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rom_addr_q  <= '0;
    end else begin
      inflight   <= issue;
      rom_addr_q <= rom_addr;
      if (br_taken) begin
        pc <= tgt_pc;
      end else if (issue) begin
        pc          <= pc + PC_W'(4);
        inflight_pc <= pc;
      end
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = inflight_pc;
    push_entry.instr = rom_data;
  end

  fetch_queue2 u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (br_taken),
    .head      (head),
    .count     (count)
  );

  assign id_valid = (count != 2'd0);
  assign id_instr = head.instr;
  assign id_pc    = head.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit with a 12-word, 1-cycle-latency ROM model
// and a stream-level reference model of the expected decode sequence.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  rom_addr;
  logic [31:0] rom_data;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [7:0]  id_pc;
  logic        br_taken = 1'b0;
  logic [7:0]  br_target = 8'h00;
  logic        fetch_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [0:11];
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= (rom_addr < 6'd12) ? rom[rom_addr] : 32'hdeadbeef;

  instruction_fetch_unit #(
    .PC_W      (8),
    .ROM_WORDS (12),
    .RESET_PC  (8'h00),
    .QDEPTH    (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .fetch_done (fetch_done)
  );

  // Advance to the next cycle: drive inputs on the falling edge, then let outputs settle.
  task automatic drive(input logic r, input logic b, input logic [7:0] t);
    @(negedge clk);
    id_ready  = r;
    br_taken  = b;
    br_target = t;
    #1;
  endtask

  // Hold reset for two cycles and release on a falling edge; the caller is then in cycle 0.
  task automatic start(input logic r);
    rst_n = 1'b0; id_ready = r; br_taken = 1'b0; br_target = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Expected decode stream after a redirect or reset: sequential in-ROM words from the target.
  task automatic model_restart(input logic [7:0] t);
    exp_q.delete();
    for (int unsigned w = 32'(t >> 2); w < 12; w++) exp_q.push_back(8'(w * 4));
  endtask

  task automatic test_reset;
    rst_n = 1'b0; id_ready = 1'b1; br_taken = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", id_valid); end
    checks++; if (id_pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", id_pc); end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", id_instr); end
    checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", fetch_done); end
    checks++; if (rom_addr !== 6'd0) begin errors++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
  endtask

  task automatic test_back_to_back;
    start(1'b1);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL b2b_cycle0_valid: got %b expected 0", id_valid); end
    drive(1'b1, 1'b0, 8'h00);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL b2b_cycle1_valid: got %b expected 0", id_valid); end
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 8'h00);
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 8'(i * 4) || id_instr !== rom[i]) begin
        errors++;
        $display("FAIL b2b_word%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                 i, id_valid, id_pc, id_instr, 8'(i * 4), rom[i]);
      end
      checks++; if (rom_addr > 6'd11) begin errors++; $display("FAIL b2b_rom_addr: got %0d expected <=11", rom_addr); end
    end
    drive(1'b1, 1'b0, 8'h00);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL end_valid: got %b expected 0", id_valid); end
    checks++; if (fetch_done !== 1'b1) begin errors++; $display("FAIL end_done: got %b expected 1", fetch_done); end
  endtask

  task automatic test_stall;
    start(1'b0);
    for (int c = 1; c <= 4; c++) begin
      drive(1'b0, 1'b0, 8'h00);
      if (c >= 2) begin
        checks++; if (rom_addr !== 6'd1) begin errors++; $display("FAIL stall_rom_addr: got %0d expected 1", rom_addr); end
      end
    end
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 8'h00) begin
      errors++; $display("FAIL stall_head: got v=%b pc=%h expected v=1 pc=00", id_valid, id_pc);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'h00);
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 8'(i * 4) || id_instr !== rom[i]) begin
        errors++;
        $display("FAIL stall_release%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                 i, id_valid, id_pc, id_instr, 8'(i * 4), rom[i]);
      end
    end
  endtask

  task automatic test_redirect;
    logic seen;
    start(1'b1);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h1a);
    drive(1'b1, 1'b0, 8'h00);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got v=%b expected 0", id_valid); end
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      if (id_valid === 1'b1) seen = 1'b1;
      else drive(1'b1, 1'b0, 8'h00);
    end
    checks++;
    if (!seen || id_pc !== 8'h18 || id_instr !== rom[6]) begin
      errors++; $display("FAIL redir_first: got v=%b pc=%h instr=%h expected v=1 pc=18 instr=%h", id_valid, id_pc, id_instr, rom[6]);
    end
    drive(1'b1, 1'b0, 8'h00);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 8'h1c || id_instr !== rom[7]) begin
      errors++; $display("FAIL redir_second: got v=%b pc=%h instr=%h expected v=1 pc=1c instr=%h", id_valid, id_pc, id_instr, rom[7]);
    end
  endtask

  task automatic test_halt_redirect;
    logic       ok;
    logic [5:0] held;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      drive(1'b1, 1'b0, 8'h00);
      if (fetch_done === 1'b1 && id_valid === 1'b0) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL halt_reach: got done=%b v=%b expected done=1 v=0", fetch_done, id_valid); end
    drive(1'b1, 1'b1, 8'h04);
    drive(1'b1, 1'b0, 8'h00);
    checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL halt_resume_done: got %b expected 0", fetch_done); end
    ok = 1'b0;
    for (int k = 0; k < 6 && !ok; k++) begin
      if (id_valid === 1'b1) ok = 1'b1;
      else drive(1'b1, 1'b0, 8'h00);
    end
    checks++;
    if (!ok || id_pc !== 8'h04 || id_instr !== 32'he3a01004) begin
      errors++; $display("FAIL halt_resume_head: got v=%b pc=%h instr=%h expected v=1 pc=04 instr=e3a01004", id_valid, id_pc, id_instr);
    end
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      drive(1'b1, 1'b0, 8'h00);
      if (fetch_done === 1'b1 && id_valid === 1'b0) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL halt_reach2: got done=%b v=%b expected done=1 v=0", fetch_done, id_valid); end
    held = rom_addr;
    drive(1'b1, 1'b1, 8'h40);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 8'h00);
      checks++;
      if (fetch_done !== 1'b1 || id_valid !== 1'b0 || rom_addr !== held) begin
        errors++; $display("FAIL halt_stay: got done=%b v=%b addr=%0d expected done=1 v=0 addr=%0d", fetch_done, id_valid, rom_addr, held);
      end
    end
  endtask

  task automatic test_reset_midstream;
    start(1'b0);
    repeat (4) drive(1'b0, 1'b0, 8'h00);
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL mid_full: got v=%b expected 1", id_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (id_valid !== 1'b0 || id_pc !== 8'h00 || fetch_done !== 1'b0) begin
      errors++; $display("FAIL mid_async_reset: got v=%b pc=%h done=%b expected v=0 pc=00 done=0", id_valid, id_pc, fetch_done);
    end
    @(negedge clk);
    rst_n = 1'b1; id_ready = 1'b1;
    #1;
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 8'h00 || id_instr !== rom[0]) begin
      errors++; $display("FAIL mid_restart: got v=%b pc=%h instr=%h expected v=1 pc=00 instr=%h", id_valid, id_pc, id_instr, rom[0]);
    end
  endtask

  task automatic check_accept(input string tag);
    logic [7:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL %s_extra: got pc=%h expected no output", tag, id_pc);
    end else begin
      e = exp_q.pop_front();
      if (id_pc !== e || id_instr !== rom[e[7:2]]) begin
        errors++; $display("FAIL %s_stream: got pc=%h instr=%h expected pc=%h instr=%h", tag, id_pc, id_instr, e, rom[e[7:2]]);
      end
    end
  endtask

  task automatic test_random_redirects;
    logic       r, b, done;
    logic [7:0] t;
    start(1'b1);
    model_restart(8'h00);
    for (int n = 0; n < 400; n++) begin
      r = ($urandom % 4) != 0;
      b = ($urandom % 12) == 0;
      t = 8'($urandom_range(0, 63));
      drive(r, b, t);
      if (b) model_restart(t);
      else if (id_valid === 1'b1 && id_ready) check_accept("rand");
      checks++; if (rom_addr > 6'd11) begin errors++; $display("FAIL rand_rom_addr: got %0d expected <=11", rom_addr); end
    end
    done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      drive(1'b1, 1'b0, 8'h00);
      if (id_valid === 1'b1) check_accept("drain");
      else if (fetch_done === 1'b1 && exp_q.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done || exp_q.size() != 0) begin
      errors++; $display("FAIL rand_drain: got done=%b pending=%0d expected done=1 pending=0", fetch_done, exp_q.size());
    end
  endtask

  initial begin
    rom[0] = 32'h13a0000c; rom[1]  = 32'he3a01004; rom[2]  = 32'he3a02008; rom[3]  = 32'he0813002;
    rom[4] = 32'he2833001; rom[5]  = 32'he1a04003; rom[6]  = 32'hc0533212; rom[7]  = 32'he0445001;
    rom[8] = 32'he3550000; rom[9]  = 32'h1afffffc; rom[10] = 32'he5805000; rom[11] = 32'he1016090;
    test_reset;
    test_back_to_back;
    test_stall;
    test_redirect;
    test_halt_redirect;
    test_reset_midstream;
    test_random_redirects;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
